// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART engine.
// Holds the parity modes, the FSM state encodings and the parity-bit calculator.
package uart_pkg;

    localparam int PARITY_NONE   = 0;
    localparam int PARITY_EVEN   = 1;
    localparam int PARITY_ODD    = 2;
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // Parity bit to place on the line; narrower words are zero-extended by the caller.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with registered write, combinational head read and a sticky overrun flag.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             overrun
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overrun_q, overrun_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d  = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d  = rd_ptr_q + (AW+1)'(do_pop);
        overrun_d = overrun_q;
        if (push && !do_push) begin
            overrun_d = 1'b1;
        end else if (do_pop) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign pop_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    assign overrun  = overrun_q;

endmodule

// File: rtl/uart_param_core.sv
// Full-duplex UART with configurable bit period, width, parity and stop bits.
// TX and RX run independently; received words and their error flags queue in a small FIFO.
module uart_param_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 25,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_pin,
    output logic                 tx_pin,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam bit HAS_PARITY = (PARITY != PARITY_NONE);

    tx_state_t            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_pin_q, tx_pin_d;
    logic                 tx_bit_end;

    assign tx_bit_end = (tx_cnt_q == CNT_LAST);
    assign tx_busy    = (tx_state_q != TX_IDLE);
    assign tx_pin     = tx_pin_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pin_d   = tx_pin_q;
        tx_ready   = (tx_state_q == TX_IDLE) ||
                     (tx_state_q == TX_STOP && tx_bit_end && tx_idx_q == STOP_LAST);
        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        end
        // tx_pin_d is the level of the bit that starts on the coming edge.
        case (tx_state_q)
            TX_IDLE: tx_pin_d = 1'b1;
            TX_START: if (tx_bit_end) begin
                tx_state_d = TX_DATA;
                tx_idx_d   = '0;
                tx_pin_d   = tx_shift_q[0];
            end
            TX_DATA: if (tx_bit_end) begin
                if (tx_idx_q == DATA_LAST) begin
                    tx_idx_d   = '0;
                    tx_state_d = HAS_PARITY ? TX_PARITY : TX_STOP;
                    tx_pin_d   = HAS_PARITY ? tx_par_q : 1'b1;
                end else begin
                    tx_idx_d   = tx_idx_q + 1'b1;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_pin_d   = tx_shift_q[1];
                end
            end
            TX_PARITY: if (tx_bit_end) begin
                tx_state_d = TX_STOP;
                tx_idx_d   = '0;
                tx_pin_d   = 1'b1;
            end
            TX_STOP: if (tx_bit_end) begin
                if (tx_idx_q == STOP_LAST) begin
                    tx_state_d = TX_IDLE;
                    tx_idx_d   = '0;
                end else begin
                    tx_idx_d   = tx_idx_q + 1'b1;
                end
                tx_pin_d = 1'b1;
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_ready && tx_valid) begin
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_idx_d   = '0;
            tx_shift_d = tx_data;
            tx_par_d   = parity_bit(MAX_DATA_BITS'(tx_data), PARITY);
            tx_pin_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_pin_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_pin_q   <= tx_pin_d;
        end
    end

    rx_state_t            rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic                 rx_bit_end;
    logic                 fifo_push;
    logic                 fifo_empty;
    logic [DATA_BITS+1:0] fifo_push_data;
    logic [DATA_BITS+1:0] fifo_head;

    assign rx_bit_end     = (rx_cnt_q == CNT_LAST);
    assign fifo_push_data = {rx_ferr_q | ~rx_sync_q, rx_perr_q, rx_shift_q};

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_bit_end ? '0 : rx_cnt_q + 1'b1;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        fifo_push  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_perr_d  = 1'b0;
                    rx_ferr_d  = 1'b0;
                end
            end
            RX_START: if (rx_cnt_q == CNT_HALF) begin
                // Half a bit in: a line back at 1 means the edge was a glitch.
                rx_cnt_d   = '0;
                rx_idx_d   = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_bit_end) begin
                rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                if (rx_idx_q == DATA_LAST) begin
                    rx_idx_d   = '0;
                    rx_state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
                end else begin
                    rx_idx_d   = rx_idx_q + 1'b1;
                end
            end
            RX_PARITY: if (rx_bit_end) begin
                rx_perr_d  = (rx_sync_q != parity_bit(MAX_DATA_BITS'(rx_shift_q), PARITY));
                rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_bit_end) begin
                rx_ferr_d = rx_ferr_q | ~rx_sync_q;
                if (rx_idx_q == STOP_LAST) begin
                    fifo_push  = 1'b1;
                    rx_idx_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
                end else begin
                    rx_idx_d   = rx_idx_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: if (rx_sync_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rx_pin;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH(DATA_BITS + 2),
        .DEPTH(FIFO_DEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(fifo_push_data),
        .pop      (rx_ready),
        .pop_data (fifo_head),
        .empty    (fifo_empty),
        .overrun  (rx_overrun)
    );

    assign rx_valid = !fifo_empty;
    assign {rx_frame_err, rx_parity_err, rx_data} = fifo_head;

endmodule

// File: tb/tb_uart_param_core.sv
// Directed bench: an 8N1 and an 8E1 instance, exercising TX timing, loopback,
// glitch rejection, FIFO overrun, break handling and reset mid-frame.
`timescale 1ns/1ps
module tb_uart_param_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8N1 instance
    logic       rx_drv_n = 1'b1;
    logic       tx_pin_n;
    logic [7:0] tx_data_n = 8'h00;
    logic       tx_valid_n = 1'b0;
    logic       tx_ready_n, tx_busy_n;
    logic [7:0] rx_data_n;
    logic       perr_n, ferr_n, rx_valid_n, ovr_n;
    logic       rx_ready_n = 1'b0;

    // 8E1 instance, optionally looped back
    logic       rx_drv_e = 1'b1;
    logic       loop_e = 1'b0;
    logic       rx_pin_e;
    logic       tx_pin_e;
    logic [7:0] tx_data_e = 8'h00;
    logic       tx_valid_e = 1'b0;
    logic       tx_ready_e, tx_busy_e;
    logic [7:0] rx_data_e;
    logic       perr_e, ferr_e, rx_valid_e, ovr_e;
    logic       rx_ready_e = 1'b0;

    assign rx_pin_e = loop_e ? tx_pin_e : rx_drv_e;

    int errors = 0;
    int checks = 0;

    uart_param_core #(.CLKS_PER_BIT(25), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_n81 (
        .clk(clk), .rst(rst), .rx_pin(rx_drv_n), .tx_pin(tx_pin_n),
        .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready_n), .tx_busy(tx_busy_n),
        .rx_data(rx_data_n), .rx_parity_err(perr_n), .rx_frame_err(ferr_n),
        .rx_valid(rx_valid_n), .rx_ready(rx_ready_n), .rx_overrun(ovr_n)
    );

    uart_param_core #(.CLKS_PER_BIT(25), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e81 (
        .clk(clk), .rst(rst), .rx_pin(rx_pin_e), .tx_pin(tx_pin_e),
        .tx_data(tx_data_e), .tx_valid(tx_valid_e), .tx_ready(tx_ready_e), .tx_busy(tx_busy_e),
        .rx_data(rx_data_e), .rx_parity_err(perr_e), .rx_frame_err(ferr_e),
        .rx_valid(rx_valid_e), .rx_ready(rx_ready_e), .rx_overrun(ovr_e)
    );

    task automatic set_rx(input bit e, input logic v);
        if (e) rx_drv_e = v;
        else   rx_drv_n = v;
    endtask

    task automatic hold_bit(input bit e, input logic v);
        set_rx(e, v);
        repeat (25) @(negedge clk);
    endtask

    task automatic drive_frame(input bit e, input logic [7:0] d, input bit with_par);
        hold_bit(e, 1'b0);
        for (int i = 0; i < 8; i++) hold_bit(e, d[i]);
        if (with_par) hold_bit(e, ^d);
        hold_bit(e, 1'b1);
    endtask

    task automatic pop(input bit e);
        if (e) rx_ready_e = 1'b1;
        else   rx_ready_n = 1'b1;
        @(negedge clk);
        rx_ready_e = 1'b0;
        rx_ready_n = 1'b0;
    endtask

    task automatic wait_valid(input bit e, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (e ? rx_valid_e : rx_valid_n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [6:0] got;
        repeat (3) @(negedge clk);
        got = {tx_pin_n, tx_ready_n, tx_busy_n, rx_valid_n, ovr_n, perr_n, ferr_n};
        checks++;
        if (got !== 7'b1100000) begin
            errors++; $display("FAIL reset_n81: got %b want 1100000", got);
        end
        checks++;
        if (rx_data_n !== 8'h00) begin
            errors++; $display("FAIL reset_n81_data: got %h want 00", rx_data_n);
        end
        got = {tx_pin_e, tx_ready_e, tx_busy_e, rx_valid_e, ovr_e, perr_e, ferr_e};
        checks++;
        if (got !== 7'b1100000) begin
            errors++; $display("FAIL reset_e81: got %b want 1100000", got);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_pin_n, tx_ready_n, rx_valid_n} !== 3'b110) begin
            errors++; $display("FAIL post_reset_idle: got %b want 110", {tx_pin_n, tx_ready_n, rx_valid_n});
        end
        $display("test_reset done");
    endtask

    task automatic test_tx_8n1;
        logic [9:0] frame;
        bit         bad;
        int         rdy_cnt;
        int         last_rdy;
        frame    = {1'b1, 8'hA5, 1'b0};
        rdy_cnt  = 0;
        last_rdy = -1;
        tx_data_n  = 8'hA5;
        tx_valid_n = 1'b1;
        @(negedge clk);
        tx_valid_n = 1'b0;
        checks++;
        if (tx_busy_n !== 1'b1) begin
            errors++; $display("FAIL tx_accept_busy: got %b want 1", tx_busy_n);
        end
        for (int b = 0; b < 10; b++) begin
            bad = 1'b0;
            for (int c = 0; c < 25; c++) begin
                if (tx_pin_n !== frame[b]) bad = 1'b1;
                if (tx_ready_n) begin
                    rdy_cnt++;
                    last_rdy = b * 25 + c;
                end
                @(negedge clk);
            end
            checks++;
            if (bad) begin
                errors++; $display("FAIL tx_a5_bit%0d: level not held at %b for 25 cycles", b, frame[b]);
            end
        end
        checks++;
        if (rdy_cnt != 1 || last_rdy != 249) begin
            errors++; $display("FAIL tx_ready_window: got %0d high cycles last at %0d, want 1 at 249", rdy_cnt, last_rdy);
        end
        checks++;
        if ({tx_busy_n, tx_pin_n} !== 2'b01) begin
            errors++; $display("FAIL tx_frame_len: busy,pin got %b want 01 at cycle 250", {tx_busy_n, tx_pin_n});
        end
        $display("test_tx_8n1: sent A5");
    endtask

    task automatic test_loopback_8e1;
        bit   gap, ok;
        logic par1, par2, rdy_at_end;
        gap = 1'b0;
        par1 = 1'bx; par2 = 1'bx; rdy_at_end = 1'b0;
        loop_e     = 1'b1;
        tx_data_e  = 8'h07;
        tx_valid_e = 1'b1;
        @(negedge clk);
        tx_data_e  = 8'h00;
        for (int c = 0; c < 550; c++) begin
            if (c == 275) tx_valid_e = 1'b0;
            if (!tx_busy_e) gap = 1'b1;
            if (c == 274) rdy_at_end = tx_ready_e;
            if (c == 237) par1 = tx_pin_e;
            if (c == 275 + 237) par2 = tx_pin_e;
            @(negedge clk);
        end
        checks++;
        if (rdy_at_end !== 1'b1) begin
            errors++; $display("FAIL b2b_ready_last_stop: got %b want 1", rdy_at_end);
        end
        checks++;
        if (gap) begin
            errors++; $display("FAIL b2b_gap: tx_busy dropped between frames, want continuous");
        end
        checks++;
        if ({par1, par2} !== 2'b10) begin
            errors++; $display("FAIL even_parity_bits: got %b want 10", {par1, par2});
        end
        checks++;
        if (tx_busy_e !== 1'b0) begin
            errors++; $display("FAIL b2b_end_busy: got %b want 0", tx_busy_e);
        end
        wait_valid(1'b1, 50, ok);
        checks++;
        if (!ok || {ferr_e, perr_e, rx_data_e} !== 10'h007) begin
            errors++; $display("FAIL loop_word0: got v=%b f=%b p=%b d=%h want v=1 f=0 p=0 d=07", ok, ferr_e, perr_e, rx_data_e);
        end
        pop(1'b1);
        wait_valid(1'b1, 100, ok);
        checks++;
        if (!ok || {ferr_e, perr_e, rx_data_e} !== 10'h000) begin
            errors++; $display("FAIL loop_word1: got v=%b f=%b p=%b d=%h want v=1 f=0 p=0 d=00", ok, ferr_e, perr_e, rx_data_e);
        end
        pop(1'b1);
        loop_e = 1'b0;
        $display("test_loopback_8e1: sent 07,00 received both");
    endtask

    task automatic test_glitch;
        bit ok;
        set_rx(1'b0, 1'b0);
        repeat (10) @(negedge clk);
        set_rx(1'b0, 1'b1);
        repeat (75) @(negedge clk);
        checks++;
        if (rx_valid_n !== 1'b0) begin
            errors++; $display("FAIL glitch_no_push: rx_valid got %b want 0", rx_valid_n);
        end
        drive_frame(1'b0, 8'h5A, 1'b0);
        wait_valid(1'b0, 20, ok);
        checks++;
        if (!ok || {ferr_n, perr_n, rx_data_n} !== 10'h05A) begin
            errors++; $display("FAIL glitch_rearm: got v=%b f=%b p=%b d=%h want v=1 f=0 p=0 d=5a", ok, ferr_n, perr_n, rx_data_n);
        end
        pop(1'b0);
        checks++;
        if (rx_valid_n !== 1'b0) begin
            errors++; $display("FAIL glitch_single_word: rx_valid got %b want 0", rx_valid_n);
        end
        $display("test_glitch: 10-cycle pulse rejected, 5A received");
    endtask

    task automatic test_overrun;
        logic [7:0] exp;
        for (int w = 0; w < 5; w++) begin
            exp = 8'h11 + 8'(w);
            drive_frame(1'b0, exp, 1'b0);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (ovr_n !== 1'b1) begin
            errors++; $display("FAIL overrun_set: got %b want 1", ovr_n);
        end
        for (int k = 0; k < 4; k++) begin
            exp = 8'h11 + 8'(k);
            checks++;
            if (rx_valid_n !== 1'b1 || rx_data_n !== exp) begin
                errors++; $display("FAIL fifo_order%0d: got v=%b d=%h want v=1 d=%h", k, rx_valid_n, rx_data_n, exp);
            end
            pop(1'b0);
            if (k == 0) begin
                checks++;
                if (ovr_n !== 1'b0) begin
                    errors++; $display("FAIL overrun_clear: got %b want 0", ovr_n);
                end
            end
        end
        checks++;
        if (rx_valid_n !== 1'b0) begin
            errors++; $display("FAIL fifo_drained: rx_valid got %b want 0", rx_valid_n);
        end
        $display("test_overrun: 11..14 kept, 15 dropped");
    endtask

    task automatic test_break;
        bit ok;
        set_rx(1'b1, 1'b0);
        repeat (500) @(negedge clk);
        set_rx(1'b1, 1'b1);
        repeat (30) @(negedge clk);
        wait_valid(1'b1, 10, ok);
        checks++;
        if (!ok || {ferr_e, perr_e, rx_data_e} !== 10'h200) begin
            errors++; $display("FAIL break_word: got v=%b f=%b p=%b d=%h want v=1 f=1 p=0 d=00", ok, ferr_e, perr_e, rx_data_e);
        end
        pop(1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (rx_valid_e !== 1'b0) begin
            errors++; $display("FAIL break_one_word: rx_valid got %b want 0", rx_valid_e);
        end
        drive_frame(1'b1, 8'h3C, 1'b1);
        wait_valid(1'b1, 20, ok);
        checks++;
        if (!ok || {ferr_e, perr_e, rx_data_e} !== 10'h03C) begin
            errors++; $display("FAIL after_break: got v=%b f=%b p=%b d=%h want v=1 f=0 p=0 d=3c", ok, ferr_e, perr_e, rx_data_e);
        end
        pop(1'b1);
        $display("test_break: one errored 00, then 3C clean");
    endtask

    task automatic test_reset_midframe;
        bit ok;
        // Leave a word in the FIFO so its loss on reset is visible.
        drive_frame(1'b1, 8'h99, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (rx_valid_e !== 1'b1) begin
            errors++; $display("FAIL preload_word: rx_valid got %b want 1", rx_valid_e);
        end
        // Partial RX of 0x81: start, bit0=1, part of bit1=0.
        hold_bit(1'b1, 1'b0);
        hold_bit(1'b1, 1'b1);
        set_rx(1'b1, 1'b0);
        tx_data_e  = 8'hFF;
        tx_valid_e = 1'b1;
        @(negedge clk);
        tx_valid_e = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if ({tx_busy_e, tx_pin_e} !== 2'b10) begin
            errors++; $display("FAIL pre_reset_tx: busy,pin got %b want 10", {tx_busy_e, tx_pin_e});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({tx_pin_e, tx_busy_e, rx_valid_e} !== 3'b100) begin
            errors++; $display("FAIL async_reset: pin,busy,valid got %b want 100", {tx_pin_e, tx_busy_e, rx_valid_e});
        end
        repeat (3) @(negedge clk);
        set_rx(1'b1, 1'b1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({tx_pin_e, rx_valid_e} !== 2'b10) begin
            errors++; $display("FAIL post_reset_quiet: pin,valid got %b want 10", {tx_pin_e, rx_valid_e});
        end
        loop_e     = 1'b1;
        tx_data_e  = 8'h42;
        tx_valid_e = 1'b1;
        @(negedge clk);
        tx_valid_e = 1'b0;
        wait_valid(1'b1, 400, ok);
        checks++;
        if (!ok || {ferr_e, perr_e, rx_data_e} !== 10'h042) begin
            errors++; $display("FAIL after_reset_42: got v=%b f=%b p=%b d=%h want v=1 f=0 p=0 d=42", ok, ferr_e, perr_e, rx_data_e);
        end
        pop(1'b1);
        checks++;
        if (rx_valid_e !== 1'b0) begin
            errors++; $display("FAIL after_reset_only_42: rx_valid got %b want 0", rx_valid_e);
        end
        loop_e = 1'b0;
        $display("test_reset_midframe: aborted FF/81, then 42 looped");
    endtask

    initial begin
        test_reset();
        test_tx_8n1();
        test_loopback_8e1();
        test_glitch();
        test_overrun();
        test_break();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
